game_over_sprite_fetch: RTL
===========================

Name: game_over_sprite_fetch

Overview:
- Read-side client of the single-cycle-latency sprite frame ROMs (19-bit read_address in, 24-bit RGB data_Out registered on Clk).
- Converts VGA draw coordinates into ROM addresses for the Game Over banner.
- Aligns the returned colour with its pixel, applies transparency and a blink schedule, and hands pixel_color/pixel_on to the colour mapper.
- Sprite position and enable are latched once per frame so the banner never tears.

Parameters:
- SPRITE_W, 128, sprite width in pixels (ROM row pitch).
- SPRITE_H, 64, sprite height in pixels (SPRITE_W*SPRITE_H ≤ ROM depth 8192).
- BLINK_FRAMES, 30, frames per blink phase (on or off), ≥1.
- TRANSPARENT, 24'h000000, ROM colour treated as see-through.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous active-high reset.
- vsync_pulse  in  1  one-Clk pulse at start of vertical blank.
- enable  in  1  request Game Over display; sampled at vsync_pulse.
- pos_x  in  10  sprite top-left X; sampled at vsync_pulse.
- pos_y  in  10  sprite top-left Y; sampled at vsync_pulse.
- DrawX  in  10  current pixel X.
- DrawY  in  10  current pixel Y.
- pixel_req  in  1  DrawX/DrawY valid this cycle.
- read_address  out  19  address to frame ROM.
- rom_data  in  24  frame ROM data_Out.
- pixel_valid  out  1  pixel_color/pixel_on correspond to a request.
- pixel_on  out  1  sprite covers this pixel (opaque, visible).
- pixel_color  out  24  sprite colour when pixel_on, else 0.

Behaviour:
- Reset (synchronous, Clk edge with Reset=1):
  - read_address=0, pixel_valid=0, pixel_on=0, pixel_color=0.
  - Shadow pos/enable = 0, blink counter = 0, state = IDLE.
  - All pipeline valid bits cleared. A reset mid-frame flushes in-flight pixels.
- Frame latch on vsync_pulse=1: shadow_x<=pos_x, shadow_y<=pos_y, shadow_en<=enable. Pixels requested in the same cycle use the old shadow values.
- State machine, advances only on vsync_pulse, evaluated with the newly sampled enable:
  - IDLE: enable=1 → ON, counter=0; otherwise stay IDLE.
  - ON: enable=0 → IDLE; counter==BLINK_FRAMES-1 → OFF, counter=0; else counter+1.
  - OFF: enable=0 → IDLE; counter==BLINK_FRAMES-1 → ON, counter=0; else counter+1.
  - visible = (state==ON).
- Stage 1 (Clk edge after request at cycle t):
  - hit = pixel_req && visible && DrawX≥shadow_x && DrawX<shadow_x+SPRITE_W && DrawY≥shadow_y && DrawY<shadow_y+SPRITE_H.
  - Compares use 11-bit unsigned arithmetic so shadow_x+SPRITE_W>1023 clips instead of wrapping.
  - read_address <= hit ? (DrawY-shadow_y)*SPRITE_W+(DrawX-shadow_x) : 0, zero-extended to 19 bits.
  - v1<=pixel_req, h1<=hit.
- Stage 2: ROM registers data internally; v2<=v1, h2<=h1.
- Stage 3 (outputs, registered):
  - pixel_valid<=v2.
  - pixel_on<=h2 && rom_data!=TRANSPARENT.
  - pixel_color<=pixel_on-condition ? rom_data : 0.
- Latency: request at cycle t → outputs valid after the 3rd rising edge (cycle t+3). Throughput is one pixel per cycle, with no stalls.
- pixel_req=0: pipeline still advances; outputs show pixel_valid=0, pixel_on=0, pixel_color=0.

Test Plan:
- Reset held 2 cycles while pixel_req=1 → all outputs 0 and read_address=0 throughout reset and for 3 cycles after release.
- enable=1, pos=(256,208), vsync pulse. Then DrawX=256,DrawY=208 → read_address=0. DrawX=383,DrawY=271 → read_address=8191. Colour 24'hFFFFFF from ROM → pixel_on=1 and pixel_color=FFFFFF exactly 3 cycles after each request.
- Same frame, DrawX=255 or DrawX=384 or DrawY=272 → read_address=0, pixel_on=0, pixel_valid=1. A ROM pixel equal to 000000 inside the box → pixel_on=0.
- pos_x=960, DrawX=1000 → hit (no wrap). DrawX=10 → miss.
- pos_x changed mid-frame from 256 to 300 without vsync → address mapping unchanged until the next vsync_pulse. After the pulse, DrawX=300 maps to column 0.
- BLINK_FRAMES=2, enable held 1 → visible frames ON,ON,OFF,OFF,ON. Dropping enable → IDLE at the next vsync, and pixel_on stays 0 in all later frames.

Source files
------------

// File: rtl/game_over_sprite_fetch.sv
`default_nettype none
// ============================================================================
// game_over_sprite_fetch : Game Over banner fetch, frame-latched and blinking
// Revision: 1.0
// ============================================================================
module game_over_sprite_fetch #(
  parameter int          SPRITE_W     = 128,
  parameter int          SPRITE_H     = 64,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [23:0] TRANSPARENT  = 24'h000000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        vsync_pulse,
  input  logic        enable,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        pixel_req,
  output logic [18:0] read_address,
  input  logic [23:0] rom_data,
  output logic        pixel_valid,
  output logic        pixel_on,
  output logic [23:0] pixel_color
);

  localparam int              c_CW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(BLINK_FRAMES - 1);
  localparam logic [10:0]     c_W11  = 11'(SPRITE_W);
  localparam logic [10:0]     c_H11  = 11'(SPRITE_H);
  localparam logic [18:0]     c_W19  = 19'(SPRITE_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  state_t          r_state;
  logic [c_CW-1:0] r_cnt;
  logic [9:0]      r_sx;
  logic [9:0]      r_sy;
  logic            r_en;
  logic            r_v1;
  logic            r_h1;
  logic            r_v2;
  logic            r_h2;

  logic [10:0]     w_x_end;
  logic [10:0]     w_y_end;
  logic            w_visible;
  logic            w_hit;
  logic [9:0]      w_dx;
  logic [9:0]      w_dy;
  logic [18:0]     w_addr;
  logic            w_opaque;

  // 11-bit bounds so a box hanging off the right/bottom edge clips, not wraps
  assign w_x_end   = {1'b0, r_sx} + c_W11;
  assign w_y_end   = {1'b0, r_sy} + c_H11;
  assign w_visible = (r_state == S_ON) && r_en;
  assign w_hit     = pixel_req && w_visible &&
                     ({1'b0, DrawX} >= {1'b0, r_sx}) && ({1'b0, DrawX} < w_x_end) &&
                     ({1'b0, DrawY} >= {1'b0, r_sy}) && ({1'b0, DrawY} < w_y_end);
  assign w_dx      = DrawX - r_sx;
  assign w_dy      = DrawY - r_sy;
  assign w_addr    = 19'(w_dy) * c_W19 + 19'(w_dx);
  assign w_opaque  = r_h2 && (rom_data != TRANSPARENT);

  // Frame latch and blink schedule; the FSM sees this cycle's enable directly
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sx    <= '0;
      r_sy    <= '0;
      r_en    <= 1'b0;
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else if (vsync_pulse) begin
      r_sx <= pos_x;
      r_sy <= pos_y;
      r_en <= enable;
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_state <= S_ON;
            r_cnt   <= '0;
          end
        end
        S_ON, S_OFF: begin
          if (!enable) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == c_LAST) begin
            r_state <= (r_state == S_ON) ? S_OFF : S_ON;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Three-stage pixel pipeline; the ROM itself supplies the middle register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      read_address <= '0;
      r_v1         <= 1'b0;
      r_h1         <= 1'b0;
      r_v2         <= 1'b0;
      r_h2         <= 1'b0;
      pixel_valid  <= 1'b0;
      pixel_on     <= 1'b0;
      pixel_color  <= '0;
    end else begin
      read_address <= w_hit ? w_addr : '0;
      r_v1         <= pixel_req;
      r_h1         <= w_hit;
      r_v2         <= r_v1;
      r_h2         <= r_h1;
      pixel_valid  <= r_v2;
      pixel_on     <= w_opaque;
      pixel_color  <= w_opaque ? rom_data : '0;
    end
  end

endmodule
`default_nettype wire
